cla_pipe_adder: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control. It generalises the team's fixed 8-bit lookahead adder to any `WIDTH` built from `GROUP`-bit lookahead cells. It adds a subtract mode, overflow and zero flags, and backpressure. It sits on the datapath between operand-issue logic and the result writeback stage.

---
 rtl/adder_pkg.sv | 14 +
 rtl/cla_group.sv | 45 ++++
 rtl/cla_pipe_adder.sv | 151 +++++++++++++++
 tb/tb_cla_pipe_adder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Number of lookahead cells needed to cover a WIDTH-bit operand.
  function automatic int grp_count(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead cell: in-group carries, sums and group G/P,
// all in flattened sum-of-products form (no ripple inside the cell).
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p_i,
  input  logic [GROUP-1:0] g_i,
  input  logic             c_i,
  output logic [GROUP-1:0] s_o,
  output logic [GROUP-1:0] c_o,
  output logic             gg_o,
  output logic             gp_o
);

  // c_o[i] is the carry into bit i; gg_o/gp_o summarise the whole cell.
  always_comb begin
    logic t;
    logic acc;
    t    = 1'b0;
    acc  = 1'b0;
    c_o  = '0;
    gg_o = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      t = c_i;
      for (int m = 0; m < i; m++) t = t & p_i[m];
      acc = t;
      for (int j = 0; j < i; j++) begin
        t = g_i[j];
        for (int m = j + 1; m < i; m++) t = t & p_i[m];
        acc = acc | t;
      end
      c_o[i] = acc;
    end
    acc = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      t = g_i[j];
      for (int m = j + 1; m < GROUP; m++) t = t & p_i[m];
      acc = acc | t;
    end
    gg_o = acc;
    gp_o = &p_i;
    s_o  = p_i ^ c_o;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// flow control. S1 registers bit and group propagate/generate terms, S2
// resolves the group carries, forms the sum and registers result + flags.
module cla_pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = grp_count(WIDTH, GROUP);

  if (WIDTH % GROUP != 0 || WIDTH < 2) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be >= 2 and a multiple of GROUP");
  end

  logic             s1_adv, s2_adv;
  logic             vld_p1_q, vld_p2_q;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_p1_d, g_p1_d, p_p1_q, g_p1_q;
  logic [NGRP-1:0]  gg_p1_d, gp_p1_d, gg_p1_q, gp_p1_q;
  logic             cin_p1_d, cin_p1_q;

  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] bitc_p2;
  logic [WIDTH-1:0] sum_p2_d, sum_p2_q;
  logic             c_out_p2_d, ovf_p2_d, zero_p2_d;
  logic             c_out_p2_q, ovf_p2_q, zero_p2_q;

  logic [WIDTH-1:0] unused_s1_sum, unused_s1_c;
  logic [NGRP-1:0]  unused_s2_gg, unused_s2_gp;

  assign s2_adv   = !vld_p2_q || out_ready;
  assign s1_adv   = !vld_p1_q || s2_adv;
  assign in_ready = s1_adv;

  // ---- S1: operand conditioning, bit and group P/G ----
  assign b_eff    = (op_e'(op) == OP_SUB) ? ~b : b;
  assign cin_p1_d = (op_e'(op) == OP_SUB) ? 1'b1 : c_in;
  assign p_p1_d   = a ^ b_eff;
  assign g_p1_d   = a & b_eff;

  for (genvar k = 0; k < NGRP; k++) begin : g_s1_cell
    cla_group #(.GROUP(GROUP)) u_cell (
      .p_i  (p_p1_d[k*GROUP +: GROUP]),
      .g_i  (g_p1_d[k*GROUP +: GROUP]),
      .c_i  (1'b0),
      .s_o  (unused_s1_sum[k*GROUP +: GROUP]),
      .c_o  (unused_s1_c[k*GROUP +: GROUP]),
      .gg_o (gg_p1_d[k]),
      .gp_o (gp_p1_d[k])
    );
  end

  // S1 data loads only when the stage advances with an accepted operand.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      p_p1_q   <= p_p1_d;
      g_p1_q   <= g_p1_d;
      gg_p1_q  <= gg_p1_d;
      gp_p1_q  <= gp_p1_d;
      cin_p1_q <= cin_p1_d;
    end
  end

  // ---- S2: flattened group-carry lookahead, sums and flags ----
  always_comb begin
    logic t;
    logic acc;
    t     = 1'b0;
    acc   = 1'b0;
    grp_c = '0;
    grp_c[0] = cin_p1_q;
    for (int k = 1; k <= NGRP; k++) begin
      t = cin_p1_q;
      for (int m = 0; m < k; m++) t = t & gp_p1_q[m];
      acc = t;
      for (int j = 0; j < k; j++) begin
        t = gg_p1_q[j];
        for (int m = j + 1; m < k; m++) t = t & gp_p1_q[m];
        acc = acc | t;
      end
      grp_c[k] = acc;
    end
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_s2_cell
    cla_group #(.GROUP(GROUP)) u_cell (
      .p_i  (p_p1_q[k*GROUP +: GROUP]),
      .g_i  (g_p1_q[k*GROUP +: GROUP]),
      .c_i  (grp_c[k]),
      .s_o  (sum_p2_d[k*GROUP +: GROUP]),
      .c_o  (bitc_p2[k*GROUP +: GROUP]),
      .gg_o (unused_s2_gg[k]),
      .gp_o (unused_s2_gp[k])
    );
  end

  assign c_out_p2_d = grp_c[NGRP];
  assign ovf_p2_d   = bitc_p2[WIDTH-1] ^ grp_c[NGRP];
  assign zero_p2_d  = ~|sum_p2_d;

  // Stage valids: reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (s1_adv) vld_p1_q <= in_valid;
      if (s2_adv) vld_p2_q <= vld_p1_q;
    end
  end

  // Output registers hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_p2_q   <= '0;
      c_out_p2_q <= 1'b0;
      ovf_p2_q   <= 1'b0;
      zero_p2_q  <= 1'b0;
    end else if (s2_adv && vld_p1_q) begin
      sum_p2_q   <= sum_p2_d;
      c_out_p2_q <= c_out_p2_d;
      ovf_p2_q   <= ovf_p2_d;
      zero_p2_q  <= zero_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign sum       = sum_p2_q;
  assign c_out     = c_out_p2_q;
  assign ovf       = ovf_p2_q;
  assign zero      = zero_p2_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed 8-bit cases plus randomized 32/4 and
// 64/8 configurations scored against an arithmetic reference model.
module tb_cla_pipe_adder;

  logic clk;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;
  bit   rand_go = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on w-bit operands.
  // Returns {sum[63:0], c_out, ovf, zero}.
  function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic op);
    logic [64:0] mask, am, bm, full;
    logic [63:0] s;
    logic        c, v, z;
    mask = (65'd1 << w) - 65'd1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    if (op) begin
      full = (am - bm) & mask;
      c    = (am >= bm);
      v    = (a[w-1] != b[w-1]) && (full[w-1] != a[w-1]);
    end else begin
      full = am + bm + {64'd0, cin};
      c    = full[w];
      full = full & mask;
      v    = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
    end
    s = full[63:0];
    z = (s == 64'd0);
    return {s, c, v, z};
  endfunction

  // ---------------- 8-bit directed instance ----------------
  logic [7:0] a8, b8, sum8;
  logic       cin8, op8, iv8, ir8, ov8, or8, co8, ovf8, z8;

  cla_pipe_adder #(.WIDTH(8), .GROUP(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .c_in(cin8), .op(op8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .c_out(co8), .ovf(ovf8), .zero(z8)
  );

  task automatic dir_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic op, input logic [7:0] es,
                        input logic ec, input logic ev, input logic ez);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; op8 = op; iv8 = 1'b1; or8 = 1'b1;
    #1 chk({tag, "_inrdy"}, 128'(ir8), 128'(1));
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk({tag, "_lat1"}, 128'(ov8), 128'(0));
    @(posedge clk); #1;
    chk({tag, "_lat2"}, 128'(ov8), 128'(1));
    chk({tag, "_res"}, 128'({sum8, co8, ovf8, z8}), 128'({es, ec, ev, ez}));
    @(posedge clk); #1;
  endtask

  logic [7:0] bpa  [4] = '{8'h12, 8'h9C, 8'hF0, 8'h7F};
  logic [7:0] bpb  [4] = '{8'h34, 8'h64, 8'h10, 8'h01};
  logic       bpop [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [66:0] m;
    logic [63:0] s;
    logic [7:0]  hold;
    int          bacc, bgot, seen;
    rst = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outvalid", 128'(ov8), 128'(0));
    chk("rst_flags", 128'({sum8, co8, ovf8, z8}), 128'(0));
    chk("rst_inready", 128'(ir8), 128'(1));
    rst = 1'b0;

    dir_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    dir_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    dir_op("add_0f_f0", 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    dir_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    dir_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

    // Backpressure: consumer stalled for 5 cycles while 4 ops are offered.
    bacc = 0; bgot = 0; hold = '0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      or8 = (cyc >= 5);
      iv8 = (bacc < 4);
      if (bacc < 4) begin
        a8 = bpa[bacc]; b8 = bpb[bacc]; op8 = bpop[bacc]; cin8 = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        chk("bp_inready_low", 128'(ir8), 128'(0));
        chk("bp_accepts", 128'(bacc), 128'(2));
        hold = sum8;
      end
      if (cyc == 4) begin
        chk("bp_hold_sum", 128'(sum8), 128'(hold));
        chk("bp_hold_valid", 128'(ov8), 128'(1));
      end
      if (iv8 && ir8) bacc++;
      if (ov8 && or8) begin
        if (bgot < 4) begin
          m = model(8, {56'd0, bpa[bgot]}, {56'd0, bpb[bgot]}, 1'b0, bpop[bgot]);
          s = m[66:3];
          chk("bp_result", 128'({sum8, co8, ovf8, z8}), 128'({s[7:0], m[2:0]}));
        end
        bgot++;
      end
    end
    chk("bp_count", 128'(bgot), 128'(4));
    chk("bp_drained", 128'(ov8), 128'(0));

    // Reset with two transactions in flight.
    @(negedge clk);
    or8 = 1'b0; iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; op8 = 1'b0;
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h04;
    @(negedge clk);
    iv8 = 1'b0;
    chk("pre_rst_valid", 128'(ov8), 128'(1));
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 128'(ov8), 128'(0));
    chk("rst_async_sum", 128'(sum8), 128'(0));
    @(negedge clk);
    rst = 1'b0; or8 = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    chk("rst_no_ghost", 128'(seen), 128'(0));
    dir_op("post_rst", 8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

    rand_go = 1'b1;
    for (int i = 0; i < 60000 && !(g_rand[0].done && g_rand[1].done); i++) @(posedge clk);
    if (!(g_rand[0].done && g_rand[1].done))
      chk("rand_timeout", 128'({g_rand[1].done, g_rand[0].done}), 128'(3));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // ---------------- randomized instances ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_rand
    localparam int W   = (gi == 0) ? 32 : 64;
    localparam int G   = (gi == 0) ? 4 : 8;
    localparam int NTX = 5000;

    logic [W-1:0] ra, rb, rsum;
    logic         rcin, rop, riv, rir, rov, ror, rco, rovf, rz;
    bit           done;

    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) u_dut (
      .clk(clk), .rst(rst), .in_valid(riv), .in_ready(rir), .a(ra), .b(rb),
      .c_in(rcin), .op(rop), .out_valid(rov), .out_ready(ror), .sum(rsum),
      .c_out(rco), .ovf(rovf), .zero(rz)
    );

    initial begin
      logic [W+2:0] q[$];
      logic [W+2:0] e;
      logic [66:0]  m;
      logic [63:0]  s, ta, tb;
      int           acc, got;
      bit           pend;
      done = 1'b0; riv = 1'b0; ror = 1'b0; ra = '0; rb = '0; rcin = 1'b0; rop = 1'b0;
      acc = 0; got = 0; pend = 1'b0; ta = '0; tb = '0;
      wait (rand_go);
      for (int cyc = 0; cyc < 40000 && got < NTX; cyc++) begin
        @(negedge clk);
        if (!pend) begin
          riv = (acc < NTX) && ($urandom_range(3) != 0);
          ta = {$urandom, $urandom};
          tb = {$urandom, $urandom};
          case ($urandom_range(7))
            0: ta = '0;
            1: ta = '1;
            2: ta = 64'd1 << (W - 1);
            default: ;
          endcase
          case ($urandom_range(7))
            0: tb = '0;
            1: tb = '1;
            2: tb = 64'd1 << (W - 1);
            default: ;
          endcase
          ra = ta[W-1:0]; rb = tb[W-1:0];
          rcin = 1'($urandom_range(1));
          rop  = 1'($urandom_range(1));
        end
        ror = ($urandom_range(3) != 0);
        #1;
        if (riv && rir) begin
          m = model(W, ta, tb, rcin, rop);
          s = m[66:3];
          e = {s[W-1:0], m[2:0]};
          q.push_back(e);
          acc++;
          pend = 1'b0;
        end else begin
          pend = riv;
        end
        if (rov && ror) begin
          if (q.size() == 0) chk("rand_extra", 128'(1), 128'(0));
          else begin
            e = q.pop_front();
            chk("rand_result", 128'({rsum, rco, rovf, rz}), 128'(e));
          end
          got++;
        end
      end
      chk("rand_count", 128'(got), 128'(NTX));
      done = 1'b1;
    end
  end

endmodule
